// File: rtl/timer_arbiter_pkg.sv
// Shared constants and helpers for the timer arbiter: FSM encodings and the
// round-robin pick used to choose the next timer owner.
package timer_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int MAX_REQ     = 32;
  localparam int IDX_W       = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // First set bit of pend at or after ptr, wrapping within n requesters.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] pend,
                                          input int unsigned n,
                                          input int unsigned ptr);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = 32'd0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = ptr + k;
      if (idx >= n) begin
        idx = idx - n;
      end
      if ((k < n) && !found && pend[idx[IDX_W-1:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// Requester-side bundle of the timer arbiter: request/cancel pulses in,
// grant/expired/owner status out.
interface timer_arbiter_if import timer_arbiter_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF
) ();

  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] cancel;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] expired;
  logic [OWNER_W-1:0] owner_id;
  logic               busy;

  modport master (output req, output cancel,
                  input grant, input expired, input owner_id, input busy);

  modport slave  (input req, input cancel,
                  output grant, output expired, output owner_id, output busy);

endinterface

// File: rtl/timer_arbiter_timer.sv
// One-shot period timer: start loads a period of CLOCK_FREQUENCY_MHZ*1000*
// TIME_MILLISECONDS cycles, done pulses once it elapses, stop aborts it.
module timer #(
  parameter int CLOCK_FREQUENCY_MHZ = 50,
  parameter int TIME_MILLISECONDS   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  output logic done
);

  localparam int PERIOD = CLOCK_FREQUENCY_MHZ * 1000 * TIME_MILLISECONDS;
  localparam int CNT_W  = $clog2(PERIOD + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             run_r;
  logic             done_r;

  // Down-counter; stop outranks start so an abort can never leak a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (stop) begin
      cnt_r  <= '0;
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      cnt_r  <= LOAD;
      run_r  <= 1'b1;
      done_r <= 1'b0;
    end else if (run_r) begin
      if (cnt_r == '0) begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r - CNT_W'(1);
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done = done_r;

endmodule

// File: rtl/timer_arbiter.sv
// Shares a single timer among NUM_REQ requesters: latches requests, grants
// round-robin, sequences start/stop and returns done to the owner as expired.
module timer_arbiter import timer_arbiter_pkg::*; #(
  parameter int NUM_REQ             = NUM_REQ_DEF,
  parameter int CLOCK_FREQUENCY_MHZ = 50,
  parameter int TIME_MILLISECONDS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  timer_arbiter_if.slave  bus
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [OW-1:0] LAST_IDX = OW'(NUM_REQ - 1);

  logic [1:0]         state_r,    state_s;
  logic [NUM_REQ-1:0] pending_r,  pending_s;
  logic [OW-1:0]      rr_ptr_r,   rr_ptr_s;
  logic [OW-1:0]      owner_id_r, owner_id_s;
  logic [NUM_REQ-1:0] grant_r,    grant_s;
  logic [NUM_REQ-1:0] expired_r,  expired_s;
  logic               busy_r,     busy_s;
  logic               start_r,    start_s;
  logic               stop_r,     stop_s;
  logic [OW-1:0]      ptr_next_s;
  logic               done_s;

  timer #(
    .CLOCK_FREQUENCY_MHZ (CLOCK_FREQUENCY_MHZ),
    .TIME_MILLISECONDS   (TIME_MILLISECONDS)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_r),
    .stop  (stop_r),
    .done  (done_s)
  );

  // Next-state logic: pending bookkeeping plus the IDLE/START/RUN sequencer.
  always_comb begin
    state_s    = state_r;
    pending_s  = pending_r;
    rr_ptr_s   = rr_ptr_r;
    owner_id_s = owner_id_r;
    grant_s    = grant_r;
    expired_s  = '0;
    busy_s     = busy_r;
    start_s    = 1'b0;
    stop_s     = 1'b0;
    ptr_next_s = (owner_id_r == LAST_IDX) ? '0 : owner_id_r + OW'(1);

    // Cancel beats req; the running owner cannot queue a second period.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.cancel[i]) begin
        pending_s[i] = 1'b0;
      end else if (bus.req[i] && !(busy_r && (owner_id_r == OW'(i)))) begin
        pending_s[i] = 1'b1;
      end else begin
        pending_s[i] = pending_r[i];
      end
    end

    case (state_r)
      ST_IDLE: begin
        if (pending_r != '0) begin
          owner_id_s = OW'(rr_pick(MAX_REQ'(pending_r), 32'(NUM_REQ), 32'(rr_ptr_r)));
          grant_s    = NUM_REQ'(1) << owner_id_s;
          busy_s     = 1'b1;
          start_s    = 1'b1;
          state_s    = ST_START;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_START: begin
        state_s = ST_RUN;
      end
      ST_RUN: begin
        // A done arriving with the owner's cancel still counts as expiry.
        if (done_s) begin
          expired_s             = grant_r;
          grant_s               = '0;
          busy_s                = 1'b0;
          pending_s[owner_id_r] = 1'b0;
          rr_ptr_s              = ptr_next_s;
          state_s               = ST_IDLE;
        end else if (bus.cancel[owner_id_r]) begin
          stop_s                = 1'b1;
          grant_s               = '0;
          busy_s                = 1'b0;
          pending_s[owner_id_r] = 1'b0;
          rr_ptr_s              = ptr_next_s;
          state_s               = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        grant_s = '0;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pending_r  <= '0;
      rr_ptr_r   <= '0;
      owner_id_r <= '0;
      grant_r    <= '0;
      expired_r  <= '0;
      busy_r     <= 1'b0;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      pending_r  <= pending_s;
      rr_ptr_r   <= rr_ptr_s;
      owner_id_r <= owner_id_s;
      grant_r    <= grant_s;
      expired_r  <= expired_s;
      busy_r     <= busy_s;
      start_r    <= start_s;
      stop_r     <= stop_s;
    end
  end

  assign bus.grant    = grant_r;
  assign bus.expired  = expired_r;
  assign bus.owner_id = owner_id_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: directed corners, a vector table of
// contention patterns and a randomized run against a rule-level model.
module tb_timer_arbiter;

  localparam int N   = 4;
  localparam int MHZ = 1;
  localparam int MS  = 1;
  localparam int T   = MHZ * 1000 * MS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  timer_arbiter_if #(.NUM_REQ(N)) bus ();

  timer_arbiter #(
    .NUM_REQ             (N),
    .CLOCK_FREQUENCY_MHZ (MHZ),
    .TIME_MILLISECONDS   (MS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    int         cnt;
    logic [7:0] order;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  function automatic int ref_pick(input logic [3:0] p, input int ptr);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (p[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.cancel = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] r, input logic [3:0] c);
    bus.req = r;
    bus.cancel = c;
    @(negedge clk);
    bus.req = '0;
    bus.cancel = '0;
  endtask

  task automatic wait_grant(input string name, input int limit);
    int n;
    n = 0;
    while (bus.grant == 4'b0000 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus.grant == 4'b0000) timeout(name);
  endtask

  task automatic wait_expired(input string name, input int limit, output int n);
    n = 0;
    while (bus.expired == 4'b0000 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus.expired == 4'b0000) timeout(name);
  endtask

  initial begin
    int         n;
    int         age;
    int         ptr;
    int         own;
    logic       seen;
    logic       fin;
    logic [1:0] exp_idx;
    logic [3:0] oh, mp, gp, eg, ee, lr, lc, r, c, g, e;

    vecs[0] = '{req: 4'b0101, cnt: 2, order: {2'd0, 2'd0, 2'd2, 2'd0}};
    vecs[1] = '{req: 4'b0010, cnt: 1, order: {2'd0, 2'd0, 2'd0, 2'd1}};
    vecs[2] = '{req: 4'b1011, cnt: 3, order: {2'd0, 2'd1, 2'd0, 2'd3}};
    vecs[3] = '{req: 4'b1111, cnt: 4, order: {2'd1, 2'd0, 2'd3, 2'd2}};
    vecs[4] = '{req: 4'b1000, cnt: 1, order: {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[5] = '{req: 4'b0011, cnt: 2, order: {2'd0, 2'd0, 2'd1, 2'd0}};

    // Reset state
    do_reset();
    chk("rst_grant",   32'(bus.grant),   32'd0);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_expired", 32'(bus.expired), 32'd0);
    chk("rst_owner",   32'(bus.owner_id), 32'd0);
    chk("rst_start",   32'(dut.u_timer.start), 32'd0);
    chk("rst_stop",    32'(dut.u_timer.stop),  32'd0);

    // Single requester: latency, one-cycle start, expiry timing
    pulse(4'b0010, 4'b0000);
    chk("t1_grant_early", 32'(bus.grant), 32'd0);
    @(negedge clk);
    chk("t1_grant", 32'(bus.grant), 32'h2);
    chk("t1_busy",  32'(bus.busy),  32'd1);
    chk("t1_owner", 32'(bus.owner_id), 32'd1);
    chk("t1_start", 32'(dut.u_timer.start), 32'd1);
    @(negedge clk);
    chk("t1_start_once", 32'(dut.u_timer.start), 32'd0);
    wait_expired("t1_expired", T + 20, n);
    chk("t1_latency", 32'(n), 32'(T + 1));
    chk("t1_expired", 32'(bus.expired), 32'h2);
    chk("t1_grant_off", 32'(bus.grant), 32'd0);
    chk("t1_busy_off",  32'(bus.busy),  32'd0);
    @(negedge clk);
    chk("t1_expired_pulse", 32'(bus.expired), 32'd0);

    // Vector table: contention and round-robin order
    do_reset();
    for (int v = 0; v < 6; v++) begin
      pulse(vecs[v].req, 4'b0000);
      for (int j = 0; j < vecs[v].cnt; j++) begin
        exp_idx = vecs[v].order[2*j +: 2];
        oh = 4'b0001 << exp_idx;
        wait_grant($sformatf("v%0d_grant%0d", v, j), 10);
        chk($sformatf("v%0d_grant%0d", v, j), 32'(bus.grant), 32'(oh));
        chk($sformatf("v%0d_owner%0d", v, j), 32'(bus.owner_id), 32'(exp_idx));
        wait_expired($sformatf("v%0d_exp%0d", v, j), T + 20, n);
        chk($sformatf("v%0d_exp%0d", v, j), 32'(bus.expired), 32'(oh));
        chk($sformatf("v%0d_gap%0d", v, j), 32'(bus.grant), 32'd0);
      end
      @(negedge clk);
      chk($sformatf("v%0d_idle", v), 32'(bus.busy), 32'd0);
    end

    // Abort of a running period
    do_reset();
    pulse(4'b1000, 4'b0000);
    wait_grant("t4_grant", 10);
    chk("t4_grant", 32'(bus.grant), 32'h8);
    repeat (100) @(negedge clk);
    pulse(4'b0000, 4'b1000);
    chk("t4_stop",    32'(dut.u_timer.stop), 32'd1);
    chk("t4_grant0",  32'(bus.grant),   32'd0);
    chk("t4_busy0",   32'(bus.busy),    32'd0);
    seen = 1'b0;
    for (int k = 0; k < T + 20; k++) begin
      seen = seen | (|bus.expired);
      @(negedge clk);
    end
    chk("t4_no_expired", 32'(seen), 32'd0);

    // Cancel of a pending (not running) requester
    pulse(4'b0101, 4'b0000);
    wait_grant("t5_grant", 10);
    chk("t5_grant", 32'(bus.grant), 32'h1);
    repeat (10) @(negedge clk);
    pulse(4'b0000, 4'b0100);
    wait_expired("t5_expired", T + 20, n);
    chk("t5_expired", 32'(bus.expired), 32'h1);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      seen = seen | bus.busy | (|bus.grant);
    end
    chk("t5_stays_idle", 32'(seen), 32'd0);

    // done and cancel[owner] together: expiry wins, no stop
    pulse(4'b0010, 4'b0000);
    wait_grant("t6_grant", 10);
    n = 0;
    while (dut.u_timer.done !== 1'b1 && n < T + 20) begin
      @(negedge clk);
      n++;
    end
    if (dut.u_timer.done !== 1'b1) timeout("t6_done");
    bus.cancel = 4'b0010;
    @(negedge clk);
    bus.cancel = 4'b0000;
    chk("t6_expired", 32'(bus.expired), 32'h2);
    chk("t6_no_stop", 32'(dut.u_timer.stop), 32'd0);

    // Asynchronous reset in the middle of a period
    repeat (3) @(negedge clk);
    pulse(4'b0100, 4'b0000);
    wait_grant("t7_grant", 10);
    chk("t7_grant", 32'(bus.grant), 32'h4);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_grant", 32'(bus.grant),   32'd0);
    chk("t7_rst_busy",  32'(bus.busy),    32'd0);
    chk("t7_rst_exp",   32'(bus.expired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < T + 20; k++) begin
      @(negedge clk);
      seen = seen | (|bus.expired) | (|bus.grant);
    end
    chk("t7_quiet_after_rst", 32'(seen), 32'd0);

    // Randomized traffic against a rule-level model
    do_reset();
    mp = '0; gp = '0; lr = '0; lc = '0; ptr = 0; age = 0; own = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      g = bus.grant;
      e = bus.expired;
      chk("rnd_onehot", 32'($onehot0(g)), 32'd1);
      chk("rnd_busy",   32'(bus.busy), 32'(|g));
      fin = 1'b0;
      if (gp == 4'b0000) begin
        eg = (mp != 4'b0000) ? (4'b0001 << ref_pick(mp, ptr)) : 4'b0000;
        ee = 4'b0000;
        age = 0;
        if (eg != 4'b0000) begin
          chk("rnd_owner", 32'(bus.owner_id), 32'(ref_pick(mp, ptr)));
        end
      end else begin
        age++;
        for (int k = 0; k < N; k++) if (gp[k]) own = k;
        if (age == T + 2) begin
          eg = 4'b0000; ee = gp; fin = 1'b1;
        end else if (lc[own] && age >= 2) begin
          eg = 4'b0000; ee = 4'b0000; fin = 1'b1;
        end else begin
          eg = gp; ee = 4'b0000;
        end
      end
      chk("rnd_grant",   32'(g), 32'(eg));
      chk("rnd_expired", 32'(e), 32'(ee));
      for (int k = 0; k < N; k++) begin
        if (lc[k]) mp[k] = 1'b0;
        else if (lr[k] && !gp[k]) mp[k] = 1'b1;
      end
      if (fin) begin
        mp[own] = 1'b0;
        ptr = (own + 1) % N;
      end
      gp = eg;
      r = ($urandom_range(0, 47) == 0) ? 4'($urandom) : 4'b0000;
      c = ($urandom_range(0, 599) == 0) ? 4'($urandom) : 4'b0000;
      if (eg != 4'b0000 && age == 0) c = c & ~eg;
      bus.req = r;
      bus.cancel = c;
      lr = r;
      lc = c;
    end
    bus.req = '0;
    bus.cancel = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
